// File: rtl/dct_buf_pkg.sv
// Shared definitions for the DCT-path block buffers: bank states, the default
// block side, and the row/column index swap used for transposed readout.
package dct_buf_pkg;

    localparam int DEFAULT_N = 8;
    localparam int IDX_MAX_W = 16;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    // Swaps the row and column fields of a linear index j = r*N + c, giving c*N + r.
    // Both fields are log2n bits wide and wrap within that width.
    function automatic logic [IDX_MAX_W-1:0] transposed_addr(
        input logic [IDX_MAX_W-1:0] j,
        input int                   log2n
    );
        logic [IDX_MAX_W-1:0] mask;
        mask = (IDX_MAX_W'(1) << log2n) - IDX_MAX_W'(1);
        return ((j & mask) << log2n) | ((j >> log2n) & mask);
    endfunction

endpackage

// File: rtl/block_bank_ram.sv
// One N*N sample bank: a single synchronous write port and an asynchronous read port.
module block_bank_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Capture one sample per accepted write.
    // NOTE: the array has no reset; the bank-state flags decide what is valid,
    // so clearing the contents would only add a wide reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/block_transpose_pingpong.sv
// Ping-pong NxN block buffer: one bank fills while the other drains, each block
// read back either in its written order or transposed.
module block_transpose_pingpong
    import dct_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N      = DEFAULT_N,
    parameter int LOG2N  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              tr_mode,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [1:0]        bank_full
);

    localparam int DEPTH  = N * N;
    localparam int ADDR_W = 2 * LOG2N;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    bank_state_e       r_bank_state [2];
    bank_state_e       w_bank_state_nxt [2];
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_w_cnt;
    logic [ADDR_W-1:0] r_j_cnt;
    logic [1:0]        r_mode;

    logic              w_wr_en;
    logic              w_load;
    logic              w_w_wrap;
    logic              w_j_wrap;
    logic              w_we0;
    logic              w_we1;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data0;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data;

    assign in_ready  = rst && (r_bank_state[r_wr_bank] != BANK_FULL);
    assign w_wr_en   = in_valid && in_ready;
    assign w_load    = (!out_valid || out_ready) && (r_bank_state[r_rd_bank] == BANK_FULL);
    assign w_w_wrap  = (r_w_cnt == LAST_IDX);
    assign w_j_wrap  = (r_j_cnt == LAST_IDX);
    assign w_we0     = w_wr_en && (r_wr_bank == 1'b0);
    assign w_we1     = w_wr_en && (r_wr_bank == 1'b1);
    assign w_rd_addr = r_mode[r_rd_bank] ? ADDR_W'(transposed_addr(IDX_MAX_W'(r_j_cnt), LOG2N))
                                         : r_j_cnt;
    assign w_rd_data = r_rd_bank ? w_rd_data1 : w_rd_data0;
    assign bank_full = {r_bank_state[1] == BANK_FULL, r_bank_state[0] == BANK_FULL};

    // Bank transitions: the filling bank turns FULL on its last write, the
    // draining bank turns EMPTY when its last sample moves to the output register.
    // NOTE: every output of this block gets its hold value first, so no path
    // through it leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_bank_state_nxt[0] = r_bank_state[0];
        w_bank_state_nxt[1] = r_bank_state[1];
        if (w_wr_en && w_w_wrap) begin
            w_bank_state_nxt[r_wr_bank] = BANK_FULL;
        end
        if (w_load && w_j_wrap) begin
            w_bank_state_nxt[r_rd_bank] = BANK_EMPTY;
        end
    end

    // Bank state register.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bank_state[0] <= BANK_EMPTY;
            r_bank_state[1] <= BANK_EMPTY;
        end else begin
            r_bank_state[0] <= w_bank_state_nxt[0];
            r_bank_state[1] <= w_bank_state_nxt[1];
        end
    end

    // Write side: advance the write counter, flip banks on wrap, latch the block mode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_w_cnt   <= '0;
            r_wr_bank <= 1'b0;
            r_mode    <= 2'b00;
        end else if (w_wr_en) begin
            r_w_cnt <= r_w_cnt + ADDR_W'(1);
            if (w_w_wrap) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (r_w_cnt == '0) begin
                r_mode[r_wr_bank] <= tr_mode;
            end
        end
    end

    // Read side: load the output register from the full bank, hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_j_cnt   <= '0;
            r_rd_bank <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (w_load) begin
            out_data  <= w_rd_data;
            out_valid <= 1'b1;
            out_last  <= w_j_wrap;
            r_j_cnt   <= r_j_cnt + ADDR_W'(1);
            if (w_j_wrap) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end else if (out_ready && out_valid) begin
            out_valid <= 1'b0;
        end
    end

    block_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .clk     (clk),
        .i_we    (w_we0),
        .i_waddr (r_w_cnt),
        .i_wdata (in_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data0)
    );

    block_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .clk     (clk),
        .i_we    (w_we1),
        .i_waddr (r_w_cnt),
        .i_wdata (in_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data1)
    );

endmodule
